fetch_queue: RTL and testbench

Instruction fetch stage with a small prefetch buffer, sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC, drives the word address of the combinational instruction memory, and queues {pc, instruction} pairs. IF/ID drains the queue through a valid/ready handshake, so a hazard stall holds IF/ID without losing fetched instructions. A taken branch resolved in EX/MEM redirects the PC and flushes the queue.

---
 rtl/fetch_queue_if.sv | 29 ++
 rtl/fetch_queue.sv | 78 +++++++
 tb/tb_fetch_queue.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - instruction memory and IF/ID handshake signals of the fetch queue
interface fetch_queue_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              out_valid;
  logic [31:0]       out_pc;
  logic [31:0]       out_inst;
  logic              out_ready;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output out_valid,
    output out_pc,
    output out_inst,
    input  out_ready
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  out_valid,
    input  out_pc,
    input  out_inst,
    output out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch PC owner and prefetch queue of {pc, inst} feeding IF/ID
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              fetch_pc,
  output logic [$clog2(DEPTH):0]   count,
  fetch_queue_if.master            bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      r_pc_mem   [DEPTH];
  logic [31:0]      r_inst_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_fetch_pc;

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = w_valid & bus.out_ready;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign w_push  = ~redirect & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_fetch_pc <= PC_RESET;
    end else if (redirect) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_fetch_pc <= redirect_pc;
    end else begin
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push) begin
        r_wptr     <= r_wptr + 1'b1;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage needs no reset: nothing is read unless count marks it occupied.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wptr]   <= r_fetch_pc;
      r_inst_mem[r_wptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_addr = r_fetch_pc[ADDR_W+1:2];
  assign bus.out_valid = w_valid;
  assign bus.out_pc    = w_valid ? r_pc_mem[r_rptr]   : 32'h0;
  assign bus.out_inst  = w_valid ? r_inst_mem[r_rptr] : NOP;
  assign fetch_pc      = r_fetch_pc;
  assign count         = r_count;
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized scoreboard bench for fetch_queue
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam int          ADDR_W   = 6;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] fetch_pc;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  fetch_queue_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_queue #(
    .DEPTH(DEPTH), .PC_RESET(PC_RESET), .ADDR_W(ADDR_W), .NOP(NOP)
  ) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_pc(fetch_pc), .count(count), .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory word k holds 32'h100 + k.
  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    logic [ADDR_W-1:0] idx;
    idx = pc[ADDR_W+1:2];
    return 32'h100 + {{(32-ADDR_W){1'b0}}, idx};
  endfunction

  assign bus.imem_rdata = 32'h100 + {{(32-ADDR_W){1'b0}}, bus.imem_addr};

  // Reference model: expected queue contents and fetch PC, stepped on every edge.
  logic [63:0] exp_q[$];
  logic [31:0] m_pc = PC_RESET;
  bit          m_pop;
  bit          m_push;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      m_pc = PC_RESET;
    end else if (redirect) begin
      exp_q.delete();
      m_pc = redirect_pc;
    end else begin
      m_pop  = (exp_q.size() != 0) && bus.out_ready;
      m_push = (exp_q.size() < DEPTH) || m_pop;
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) begin
        exp_q.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor compares the DUT head and status against the scoreboard away from the edge.
  always @(negedge clk) begin
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [ADDR_W-1:0] e_addr;
    e_pc   = (exp_q.size() != 0) ? exp_q[0][63:32] : 32'h0;
    e_inst = (exp_q.size() != 0) ? exp_q[0][31:0]  : NOP;
    e_addr = m_pc[ADDR_W+1:2];
    check("mon_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
    check("mon_count", 64'(count), 64'(exp_q.size()));
    check("mon_fetch_pc", 64'(fetch_pc), 64'(m_pc));
    check("mon_imem_addr", 64'(bus.imem_addr), 64'(e_addr));
    check("mon_out_pc", 64'(bus.out_pc), 64'(e_pc));
    check("mon_out_inst", 64'(bus.out_inst), 64'(e_inst));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    bus.out_ready = 1'b1;
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_inst", 64'(bus.out_inst), 64'(NOP));
    check("rst_fetch_pc", 64'(fetch_pc), 64'(PC_RESET));
    step();
    step();
    rst = 1'b1;

    // Streaming with out_ready held high.
    for (int k = 0; k < 8; k++) begin
      step();
      check("stream_pc", 64'(bus.out_pc), 64'(4 * k));
      check("stream_inst", 64'(bus.out_inst), 64'(32'h100 + k));
      check("stream_count", 64'(count), 64'd1);
    end

    // Fill and stall.
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("fill_count", 64'(count), 64'd4);
    step();
    step();
    check("stall_fetch_pc", 64'(fetch_pc), 64'd16);
    check("stall_head", 64'(bus.out_pc), 64'd0);

    // Full queue with a single-cycle pop.
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("full_pp_count", 64'(count), 64'd4);
    check("full_pp_fetch_pc", 64'(fetch_pc), 64'd20);
    check("full_pp_head", 64'(bus.out_pc), 64'd4);
    step();
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      check("drain_order", 64'(bus.out_pc), 64'(4 * k));
      step();
    end

    // Redirect with three entries queued.
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("pre_redir_count", 64'(count), 64'd3);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    check("redir_valid", 64'(bus.out_valid), 64'd0);
    check("redir_inst", 64'(bus.out_inst), 64'(NOP));
    step();
    check("redir_pc", 64'(bus.out_pc), 64'h40);
    check("redir_word", 64'(bus.out_inst), 64'h110);

    // Redirect with a simultaneous pop, to the top of the address space.
    bus.out_ready = 1'b1;
    step();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("wrap_flush_count", 64'(count), 64'd0);
    check("wrap_addr_hi", 64'(bus.imem_addr), 64'd63);
    step();
    check("wrap_head_pc", 64'(bus.out_pc), 64'hFFFF_FFFC);
    check("wrap_addr_lo", 64'(bus.imem_addr), 64'd0);
    check("wrap_fetch_pc", 64'(fetch_pc), 64'd0);
    step();
    check("wrap_next_pc", 64'(bus.out_pc), 64'd0);
    check("wrap_count", 64'(count), 64'd1);

    // Asynchronous reset between edges.
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("pre_arst_count", 64'(count), 64'd3);
    #1;
    rst = 1'b0;
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_fetch_pc", 64'(fetch_pc), 64'(PC_RESET));
    step();
    rst = 1'b1;

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      step();
    end
    redirect = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
